// File: rtl/register_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : register_file_pkg
// Description : Shared defaults and helpers for the multi-port register file.
//               Holds the default geometry (data width, register count, read
//               port count), the hard-wired zero register index and the
//               address-width helper used by every other file.
// Revision    : 1.0 - initial release
// ============================================================================
package register_file_pkg;

    localparam int N_DEFAULT        = 32;
    localparam int DEPTH_DEFAULT    = 32;
    localparam int RD_PORTS_DEFAULT = 2;

    // Architectural register that always reads zero and is never written.
    localparam int REG_ZERO         = 0;

    // Address width for a register file of the given depth, never below 1.
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/register_file_mp_if.sv
`default_nettype none
// ============================================================================
// Module      : register_file_mp_if
// Description : Bus interface of the multi-port register file.
//               master : drives write, issue and read-address signals
//               slave  : the register file; returns read data, per-port
//                        readiness and the pending-register count
//               Signals: Reg_Write / Write_Register / Write_Data (write port)
//                        Issue_Valid / Issue_Register (scoreboard set)
//                        Read_Register / Read_Data / Read_Ready (packed ports)
//                        Pending_Count (registered popcount of pending bits)
// Revision    : 1.0 - initial release
// ============================================================================
interface register_file_mp_if
    import register_file_pkg::*;
#(
    parameter int N        = N_DEFAULT,
    parameter int DEPTH    = DEPTH_DEFAULT,
    parameter int RD_PORTS = RD_PORTS_DEFAULT
) ();

    localparam int ADDR_W = addr_width(DEPTH);

    logic                         Reg_Write;
    logic [ADDR_W-1:0]            Write_Register;
    logic [N-1:0]                 Write_Data;
    logic                         Issue_Valid;
    logic [ADDR_W-1:0]            Issue_Register;
    logic [RD_PORTS*ADDR_W-1:0]   Read_Register;
    logic [RD_PORTS*N-1:0]        Read_Data;
    logic [RD_PORTS-1:0]          Read_Ready;
    logic [ADDR_W:0]              Pending_Count;

    modport master (
        output Reg_Write, Write_Register, Write_Data,
        output Issue_Valid, Issue_Register, Read_Register,
        input  Read_Data, Read_Ready, Pending_Count
    );

    modport slave (
        input  Reg_Write, Write_Register, Write_Data,
        input  Issue_Valid, Issue_Register, Read_Register,
        output Read_Data, Read_Ready, Pending_Count
    );

endinterface
`default_nettype wire

// File: rtl/register_file_read_port.sv
`default_nettype none
// ============================================================================
// Module      : register_file_read_port
// Description : One combinational read port of the register file.
//               addr_i      : read address
//               regs_i      : flattened contents of registers 1..DEPTH-1
//               pending_i   : pending bits of registers 1..DEPTH-1
//               wr_en_i / wr_addr_i / wr_data_i : same-cycle write, forwarded
//               data_o      : operand (zero for register 0 / out of range)
//               ready_o     : operand valid this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_read_port
    import register_file_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  wire logic [addr_width(DEPTH)-1:0] addr_i,
    input  wire logic [(DEPTH-1)*N-1:0]       regs_i,
    input  wire logic [DEPTH-1:1]             pending_i,
    input  wire logic                         wr_en_i,
    input  wire logic [addr_width(DEPTH)-1:0] wr_addr_i,
    input  wire logic [N-1:0]                 wr_data_i,
    output logic      [N-1:0]                 data_o,
    output logic                              ready_o
);

    localparam int ADDR_W = addr_width(DEPTH);

    logic [N-1:0] w_sel_data;
    logic         w_sel_pend;
    logic         w_in_range;
    logic         w_fwd;

    // The decode only matches real, writable registers, so register 0 and
    // addresses beyond DEPTH fall through with zero data and no pending bit.
    always_comb begin
        w_sel_data = '0;
        w_sel_pend = 1'b0;
        w_in_range = 1'b0;
        for (int r = REG_ZERO + 1; r < DEPTH; r++) begin
            if (addr_i == ADDR_W'(r)) begin
                w_sel_data = regs_i[(r-1)*N +: N];
                w_sel_pend = pending_i[r];
                w_in_range = 1'b1;
            end
        end
    end

    // Forwarding stays live during reset: it depends only on the write inputs.
    assign w_fwd   = wr_en_i && w_in_range && (wr_addr_i == addr_i);
    assign data_o  = w_fwd ? wr_data_i : w_sel_data;
    assign ready_o = !w_sel_pend || w_fwd;

endmodule
`default_nettype wire

// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : register_file_mp
// Description : Multi-port register file with a pending-write scoreboard.
//               clk    : rising-edge clock
//               reset  : asynchronous active-low reset
//               bus    : register_file_mp_if slave (write port, issue port,
//                        RD_PORTS combinational read ports with forwarding,
//                        per-port readiness and registered pending count)
//               Register 0 is hard-wired zero; addresses >= DEPTH read zero,
//               are always ready and ignored for writes and issues.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_mp
    import register_file_pkg::*;
#(
    parameter int N        = N_DEFAULT,
    parameter int DEPTH    = DEPTH_DEFAULT,
    parameter int RD_PORTS = RD_PORTS_DEFAULT
) (
    input  wire logic          clk,
    input  wire logic          reset,
    register_file_mp_if.slave  bus
);

    localparam int ADDR_W = addr_width(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    // Only registers 1..DEPTH-1 have storage; register 0 has none at all.
    logic [(DEPTH-1)*N-1:0] regs_q,    regs_d;
    logic [DEPTH-1:1]       pending_q, pending_d;
    logic [CNT_W-1:0]       count_q,   count_d;

    logic [RD_PORTS*N-1:0]  w_rd_data;
    logic [RD_PORTS-1:0]    w_rd_ready;

    always_comb begin
        regs_d    = regs_q;
        pending_d = pending_q;
        count_d   = '0;
        for (int r = REG_ZERO + 1; r < DEPTH; r++) begin
            if (bus.Reg_Write && (bus.Write_Register == ADDR_W'(r))) begin
                regs_d[(r-1)*N +: N] = bus.Write_Data;
                pending_d[r]         = 1'b0;
            end
            // Applied after the clear so a same-cycle issue (new producer)
            // keeps the register pending.
            if (bus.Issue_Valid && (bus.Issue_Register == ADDR_W'(r))) begin
                pending_d[r] = 1'b1;
            end
        end
        for (int r = REG_ZERO + 1; r < DEPTH; r++) begin
            count_d = count_d + CNT_W'(pending_d[r]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs_q    <= '0;
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            regs_q    <= regs_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd_port
        register_file_read_port #(
            .N     (N),
            .DEPTH (DEPTH)
        ) u_rd_port (
            .addr_i    (bus.Read_Register[p*ADDR_W +: ADDR_W]),
            .regs_i    (regs_q),
            .pending_i (pending_q),
            .wr_en_i   (bus.Reg_Write),
            .wr_addr_i (bus.Write_Register),
            .wr_data_i (bus.Write_Data),
            .data_o    (w_rd_data[p*N +: N]),
            .ready_o   (w_rd_ready[p])
        );
    end

    assign bus.Read_Data     = w_rd_data;
    assign bus.Read_Ready    = w_rd_ready;
    assign bus.Pending_Count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file_mp
// Description : Self-checking bench for register_file_mp. Two instances share
//               one stimulus stream: A (DEPTH=32, 2 ports) and B (DEPTH=24,
//               3 ports). A behavioural array model predicts every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_mp;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;

    logic        rw = 1'b0;
    logic [4:0]  wa = '0;
    logic [31:0] wd = '0;
    logic        iv = 1'b0;
    logic [4:0]  ia = '0;
    logic [4:0]  ra [3] = '{default: '0};

    int checks   = 0;
    int failures = 0;

    // Behavioural state: plain arrays indexed by register number.
    logic [31:0] mem_a  [32] = '{default: '0};
    logic [31:0] mem_b  [32] = '{default: '0};
    bit          pend_a [32] = '{default: 1'b0};
    bit          pend_b [32] = '{default: 1'b0};

    always #5 clk = ~clk;

    register_file_mp_if #(.N(32), .DEPTH(32), .RD_PORTS(2)) bus_a ();
    register_file_mp_if #(.N(32), .DEPTH(24), .RD_PORTS(3)) bus_b ();

    assign bus_a.Reg_Write      = rw;
    assign bus_a.Write_Register = wa;
    assign bus_a.Write_Data     = wd;
    assign bus_a.Issue_Valid    = iv;
    assign bus_a.Issue_Register = ia;
    assign bus_a.Read_Register  = {ra[1], ra[0]};

    assign bus_b.Reg_Write      = rw;
    assign bus_b.Write_Register = wa;
    assign bus_b.Write_Data     = wd;
    assign bus_b.Issue_Valid    = iv;
    assign bus_b.Issue_Register = ia;
    assign bus_b.Read_Register  = {ra[2], ra[1], ra[0]};

    register_file_mp #(.N(32), .DEPTH(32), .RD_PORTS(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    register_file_mp #(.N(32), .DEPTH(24), .RD_PORTS(3)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    // Reference model: writes to valid nonzero registers store data and clear
    // pending; issues set pending afterwards, so the new producer wins.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                mem_a[i]  <= '0;
                mem_b[i]  <= '0;
                pend_a[i] <= 1'b0;
                pend_b[i] <= 1'b0;
            end
        end else begin
            if (rw && wa != 0) begin
                mem_a[wa]  <= wd;
                pend_a[wa] <= 1'b0;
                if (wa < 24) begin
                    mem_b[wa]  <= wd;
                    pend_b[wa] <= 1'b0;
                end
            end
            if (iv && ia != 0) begin
                pend_a[ia] <= 1'b1;
                if (ia < 24) pend_b[ia] <= 1'b1;
            end
        end
    end

    function automatic logic [31:0] exp_data(input bit is_b, input logic [4:0] a);
        int depth;
        depth = is_b ? 24 : 32;
        if (a == 0 || int'(a) >= depth) return '0;
        if (rw && wa == a)              return wd;
        return is_b ? mem_b[a] : mem_a[a];
    endfunction

    function automatic logic [31:0] exp_ready(input bit is_b, input logic [4:0] a);
        int depth;
        depth = is_b ? 24 : 32;
        if (a == 0 || int'(a) >= depth) return 32'd1;
        if (rw && wa == a)              return 32'd1;
        return (is_b ? pend_b[a] : pend_a[a]) ? 32'd0 : 32'd1;
    endfunction

    function automatic logic [31:0] exp_count(input bit is_b);
        int s;
        s = 0;
        for (int i = 0; i < 32; i++) s += is_b ? int'(pend_b[i]) : int'(pend_a[i]);
        return 32'(s);
    endfunction

    task automatic cmp(input string nm, input int p, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s port%0d at %0t: got %h expected %h", nm, p, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, on the inactive clock edge.
    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            cmp("a_data",  p, bus_a.Read_Data[p*32 +: 32], exp_data(1'b0, ra[p]));
            cmp("a_ready", p, 32'(bus_a.Read_Ready[p]),    exp_ready(1'b0, ra[p]));
        end
        for (int p = 0; p < 3; p++) begin
            cmp("b_data",  p, bus_b.Read_Data[p*32 +: 32], exp_data(1'b1, ra[p]));
            cmp("b_ready", p, 32'(bus_b.Read_Ready[p]),    exp_ready(1'b1, ra[p]));
        end
        cmp("a_count", 0, 32'(bus_a.Pending_Count), exp_count(1'b0));
        cmp("b_count", 0, 32'(bus_b.Pending_Count), exp_count(1'b1));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] pick();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                           : 5'($urandom_range(0, 9));
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;

        // Write x5, read it back next cycle.
        cyc(); rw = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        cyc(); rw = 1'b0; ra[0] = 5'd5;
        #1;
        cmp("lit_x5_data",  0, bus_a.Read_Data[31:0],     32'hDEADBEEF);
        cmp("lit_x5_ready", 0, 32'(bus_a.Read_Ready[0]),  32'd1);

        // Writes to x0 are discarded.
        cyc(); rw = 1'b1; wa = 5'd0; wd = 32'h12345678; ra[0] = 5'd0; ra[1] = 5'd0; ra[2] = 5'd0;
        #1;
        cmp("lit_x0_data0", 0, bus_a.Read_Data[31:0],  32'h0);
        cmp("lit_x0_data1", 1, bus_a.Read_Data[63:32], 32'h0);
        cyc(); rw = 1'b0;
        #1;
        cmp("lit_x0_ready", 0, 32'(bus_a.Read_Ready),    32'h3);
        cmp("lit_x0_count", 0, 32'(bus_a.Pending_Count), 32'h0);

        // Same-cycle forwarding on port 1.
        cyc(); rw = 1'b1; wa = 5'd7; wd = 32'h11;
        cyc(); wd = 32'hAA; ra[1] = 5'd7;
        #1;
        cmp("lit_fwd_x7", 1, bus_a.Read_Data[63:32], 32'hAA);

        // Issue x3, observe not-ready, then the write makes it ready.
        cyc(); rw = 1'b0; iv = 1'b1; ia = 5'd3;
        cyc(); iv = 1'b0; ra[0] = 5'd3;
        #1;
        cmp("lit_x3_notready", 0, 32'(bus_a.Read_Ready[0]),  32'd0);
        cmp("lit_x3_count1",   0, 32'(bus_a.Pending_Count),  32'd1);
        cyc(); rw = 1'b1; wa = 5'd3; wd = 32'h5;
        #1;
        cmp("lit_x3_fwdready", 0, 32'(bus_a.Read_Ready[0]),  32'd1);
        cyc(); rw = 1'b0;
        #1;
        cmp("lit_x3_count0",   0, 32'(bus_a.Pending_Count),  32'd0);
        cmp("lit_x3_data",     0, bus_a.Read_Data[31:0],     32'h5);

        // Issue and write x9 together: data lands, pending stays.
        cyc(); iv = 1'b1; ia = 5'd9; rw = 1'b1; wa = 5'd9; wd = 32'h99;
        cyc(); iv = 1'b0; rw = 1'b0; ra[0] = 5'd9;
        #1;
        cmp("lit_x9_count", 0, 32'(bus_a.Pending_Count), 32'd1);
        cmp("lit_x9_data",  0, bus_a.Read_Data[31:0],    32'h99);
        cmp("lit_x9_ready", 0, 32'(bus_a.Read_Ready[0]), 32'd0);

        // x4 = 0xFF and pending, then reset mid-cycle.
        cyc(); rw = 1'b1; wa = 5'd4; wd = 32'hFF; iv = 1'b1; ia = 5'd4;
        cyc(); rw = 1'b0; iv = 1'b0; ra[0] = 5'd4; ra[1] = 5'd9; ra[2] = 5'd28;
        #1;
        cmp("lit_x4_data",  0, bus_a.Read_Data[31:0],    32'hFF);
        cmp("lit_x4_count", 0, 32'(bus_a.Pending_Count), 32'd2);
        #1 reset = 1'b0;
        #1;
        cmp("lit_rst_data",    0, bus_a.Read_Data[31:0],    32'h0);
        cmp("lit_rst_count",   0, 32'(bus_a.Pending_Count), 32'd0);
        cmp("lit_rst_ready",   0, 32'(bus_a.Read_Ready),    32'h3);
        cmp("lit_rst_b28",     2, bus_b.Read_Data[95:64],   32'h0);
        cmp("lit_rst_b_ready", 0, 32'(bus_b.Read_Ready),    32'h7);
        cyc(); rw = 1'b1; wa = 5'd6; wd = 32'hCAFE0006; ra[0] = 5'd6;
        #1;
        cmp("lit_rst_fwd", 0, bus_a.Read_Data[31:0], 32'hCAFE0006);
        #2 reset = 1'b1;
        cyc(); rw = 1'b0;
        #1;
        cmp("lit_first_wr", 0, bus_a.Read_Data[31:0], 32'hCAFE0006);

        // Randomized traffic with occasional mid-cycle reset pulses.
        for (int n = 0; n < 800; n++) begin
            cyc();
            rw = ($urandom_range(0, 2) != 0);
            wa = pick();
            wd = $urandom;
            iv = ($urandom_range(0, 2) == 0);
            ia = pick();
            for (int p = 0; p < 3; p++) ra[p] = ($urandom_range(0, 3) == 0) ? wa : pick();
            if (reset && $urandom_range(0, 80) == 0)        #2 reset = 1'b0;
            else if (!reset && $urandom_range(0, 1) == 0)   #2 reset = 1'b1;
        end

        cyc();
        rw = 1'b0; iv = 1'b0;
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
